// File: rtl/timestamp_capture_if.sv
// Read-side stream of timestamp_capture: one {ts, seq} record per valid/ready beat.
// master = capture block (producer), slave = software/DMA consumer.
interface timestamp_capture_if #(
    parameter int SEQ_W = 8
);
    logic             out_valid;
    logic             out_ready;
    logic [63:0]      out_ts;
    logic [SEQ_W-1:0] out_seq;

    modport master (
        output out_valid,
        output out_ts,
        output out_seq,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_ts,
        input  out_seq,
        output out_ready
    );
endinterface

// File: rtl/timestamp_capture.sv
// Captures the 64-bit counter on each rising edge of evt into a sequence-tagged FIFO.
// Optional macro TS_SYNC_EN adds a 2-flop evt synchronizer with a -2 timestamp correction.
module timestamp_capture #(
    parameter int DEPTH  = 8,
    parameter int SEQ_W  = 8,
    parameter int DROP_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [63:0]            count,
    input  logic                   evt,
    timestamp_capture_if.master    rd,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow,
    output logic [DROP_W-1:0]      drop_cnt,
    input  logic                   clr_ovf
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [DROP_W-1:0] DROP_MAX = {DROP_W{1'b1}};

    logic        evt_src;
    logic [63:0] ts_in;

`ifdef TS_SYNC_EN
    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;

    // Synchronizer stages are plain shifts of the raw event
    always_comb begin
        sync1_d = evt;
        sync2_d = sync1_q;
    end

    // Synchronizer flops reset high so an event held through reset is not an edge
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign evt_src = sync2_q;
    // The edge reaches the detector two cycles after it was first sampled
    assign ts_in   = count - 64'd2;
`else
    assign evt_src = evt;
    assign ts_in   = count;
`endif

    logic              evt_q, evt_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]     level_q, level_d;
    logic [SEQ_W-1:0]  seq_q, seq_d;
    logic              out_valid_q, out_valid_d;
    logic              overflow_q, overflow_d;
    logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

    logic [63:0]       ts_mem_q  [DEPTH];
    logic [SEQ_W-1:0]  seq_mem_q [DEPTH];

    logic              rise;
    logic              full;
    logic              pop;
    logic              push;
    logic              drop;
    logic [AW-1:0]     wr_idx;
    logic [AW-1:0]     rd_idx;

    assign wr_idx = wr_ptr_q[AW-1:0];
    assign rd_idx = rd_ptr_q[AW-1:0];

    // Edge detect, push/pop/drop decisions and next state of all control flops
    always_comb begin
        evt_d = evt_src;
        rise  = evt_src & ~evt_q;
        full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        pop   = out_valid_q & rd.out_ready;
        // A full FIFO still accepts a record when the head leaves in the same cycle
        push  = rise & (~full | pop);
        drop  = rise & full & ~pop;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1'b1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1'b1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        out_valid_d = (wr_ptr_d != rd_ptr_d);

        case ({push, pop})
            2'b10:   level_d = level_q + PW'(1'b1);
            2'b01:   level_d = level_q - PW'(1'b1);
            default: level_d = level_q;
        endcase

        // Dropped edges still consume a sequence number so the consumer sees the gap
        if (rise) begin
            seq_d = seq_q + SEQ_W'(1'b1);
        end else begin
            seq_d = seq_q;
        end

        // A drop outranks a simultaneous clear: the new loss must stay visible
        if (drop) begin
            overflow_d = 1'b1;
            if (clr_ovf) begin
                drop_cnt_d = DROP_W'(1'b1);
            end else if (drop_cnt_q == DROP_MAX) begin
                drop_cnt_d = drop_cnt_q;
            end else begin
                drop_cnt_d = drop_cnt_q + DROP_W'(1'b1);
            end
        end else if (clr_ovf) begin
            overflow_d = 1'b0;
            drop_cnt_d = {DROP_W{1'b0}};
        end else begin
            overflow_d = overflow_q;
            drop_cnt_d = drop_cnt_q;
        end
    end

    // Control state register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            evt_q       <= 1'b1;
            wr_ptr_q    <= {PW{1'b0}};
            rd_ptr_q    <= {PW{1'b0}};
            level_q     <= {PW{1'b0}};
            seq_q       <= {SEQ_W{1'b0}};
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            drop_cnt_q  <= {DROP_W{1'b0}};
        end else begin
            evt_q       <= evt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            seq_q       <= seq_d;
            out_valid_q <= out_valid_d;
            overflow_q  <= overflow_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    // Record storage; contents are meaningless outside the pointer window, so no reset
    always_ff @(posedge clk) begin
        if (push) begin
            ts_mem_q[wr_idx]  <= ts_in;
            seq_mem_q[wr_idx] <= seq_q;
        end
    end

    assign rd.out_valid = out_valid_q;
    assign rd.out_ts    = ts_mem_q[rd_idx];
    assign rd.out_seq   = seq_mem_q[rd_idx];
    assign level        = level_q;
    assign overflow     = overflow_q;
    assign drop_cnt     = drop_cnt_q;

endmodule

// File: tb/tb_timestamp_capture.sv
// Self-checking bench for timestamp_capture: directed scenarios plus a random phase,
// all cycles compared against a queue-based reference model.
`timescale 1ns/1ps
module tb_timestamp_capture;
    localparam int DEPTH  = 8;
    localparam int SEQ_W  = 8;
    localparam int DROP_W = 4;
    localparam int LW     = $clog2(DEPTH) + 1;
    localparam int MAXD   = (1 << DROP_W) - 1;
`ifdef TS_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              evt;
    logic              clr_ovf;
    logic [63:0]       count;
    logic [LW-1:0]     level;
    logic              overflow;
    logic [DROP_W-1:0] drop_cnt;

    timestamp_capture_if #(.SEQ_W(SEQ_W)) rd_if ();

    timestamp_capture #(.DEPTH(DEPTH), .SEQ_W(SEQ_W), .DROP_W(DROP_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .count    (count),
        .evt      (evt),
        .rd       (rd_if),
        .level    (level),
        .overflow (overflow),
        .drop_cnt (drop_cnt),
        .clr_ovf  (clr_ovf)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: FIFO contents as queues, edge pipeline models detection latency
    logic [63:0]      m_ts  [$];
    logic [SEQ_W-1:0] m_seq [$];
    bit               p_v   [$];
    logic [63:0]      p_ts  [$];
    bit               m_prev;
    int               m_seqc;
    bit               m_ovf;
    int               m_drop;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ts.delete();
        m_seq.delete();
        p_v.delete();
        p_ts.delete();
        for (int i = 0; i < LAT - 1; i++) begin
            p_v.push_back(1'b0);
            p_ts.push_back(64'd0);
        end
        m_prev = 1'b1;
        m_seqc = 0;
        m_ovf  = 1'b0;
        m_drop = 0;
    endtask

    task automatic model_clock();
        bit          e;
        bit          dp;
        bit          pop;
        bit          acc;
        bit          drp;
        logic [63:0] t;
        if (rst) begin
            model_reset();
        end else begin
            e      = evt && !m_prev;
            m_prev = evt;
            p_v.push_back(e);
            p_ts.push_back(count);
            dp  = p_v.pop_front();
            t   = p_ts.pop_front();
            pop = (m_ts.size() > 0) && rd_if.out_ready;
            acc = dp && ((m_ts.size() < DEPTH) || pop);
            drp = dp && !acc;
            if (pop) begin
                void'(m_ts.pop_front());
                void'(m_seq.pop_front());
            end
            if (acc) begin
                m_ts.push_back(t);
                m_seq.push_back(SEQ_W'(m_seqc));
            end
            if (dp) m_seqc = (m_seqc + 1) % (1 << SEQ_W);
            if (drp) begin
                m_ovf  = 1'b1;
                m_drop = clr_ovf ? 1 : ((m_drop == MAXD) ? MAXD : m_drop + 1);
            end else if (clr_ovf) begin
                m_ovf  = 1'b0;
                m_drop = 0;
            end
        end
    endtask

    // One clock: model follows the posedge, outputs compared at the negedge
    task automatic step();
        @(posedge clk);
        model_clock();
        @(negedge clk);
        count = count + 64'd1;
        check("valid", 64'(rd_if.out_valid), 64'(m_ts.size() > 0));
        check("level", 64'(level), 64'(m_ts.size()));
        check("overflow", 64'(overflow), 64'(m_ovf));
        check("drop_cnt", 64'(drop_cnt), 64'(m_drop));
        if (m_ts.size() > 0) begin
            check("head_ts", rd_if.out_ts, m_ts[0]);
            check("head_seq", 64'(rd_if.out_seq), 64'(m_seq[0]));
        end
    endtask

    task automatic run_to(input logic [63:0] target);
        int n = 0;
        while (count != target && n < 1000) begin
            step();
            n++;
        end
        check("run_to_bound", count, target);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic pulses(input int n);
        for (int i = 0; i < n; i++) begin
            evt = 1'b1;
            step();
            evt = 1'b0;
            step();
        end
    endtask

    task automatic settle();
        for (int i = 0; i < LAT; i++) step();
    endtask

    logic [63:0] t_new;

    initial begin
        rst            = 1'b1;
        evt            = 1'b0;
        clr_ovf        = 1'b0;
        rd_if.out_ready = 1'b1;
        count          = 64'd100;
        model_reset();

        // Single event held 4 cycles at count=105
        step();
        step();
        check("rst_valid", 64'(rd_if.out_valid), 64'd0);
        check("rst_level", 64'(level), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        check("rst_drop", 64'(drop_cnt), 64'd0);
        rst = 1'b0;
        run_to(64'd105);
        evt = 1'b1;
        settle();
        check("single_valid", 64'(rd_if.out_valid), 64'd1);
        check("single_ts", rd_if.out_ts, 64'd105);
        check("single_seq", 64'(rd_if.out_seq), 64'd0);
        step();
        check("single_popped", 64'(rd_if.out_valid), 64'd0);
        for (int i = LAT + 1; i < 4; i++) step();
        evt = 1'b0;
        settle();
        step();
        check("single_once", 64'(rd_if.out_valid), 64'd0);
        check("single_level", 64'(level), 64'd0);

        // Fill and overflow with 10 pulses, then drain in order
        do_reset();
        rd_if.out_ready = 1'b0;
        pulses(10);
        settle();
        check("fill_level", 64'(level), 64'd8);
        check("fill_overflow", 64'(overflow), 64'd1);
        check("fill_drop", 64'(drop_cnt), 64'd2);
        rd_if.out_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            check("drain_seq", 64'(rd_if.out_seq), 64'(i));
            step();
        end
        check("drain_empty", 64'(rd_if.out_valid), 64'd0);
        rd_if.out_ready = 1'b0;
        evt = 1'b1;
        step();
        evt = 1'b0;
        for (int i = 0; i < LAT - 1; i++) step();
        check("gap_seq", 64'(rd_if.out_seq), 64'd10);
        rd_if.out_ready = 1'b1;
        step();

        // Full FIFO, rise and pop in the same cycle
        do_reset();
        rd_if.out_ready = 1'b0;
        pulses(DEPTH);
        settle();
        check("full_level", 64'(level), 64'd8);
        evt   = 1'b1;
        t_new = count;
        for (int i = 0; i < LAT - 1; i++) begin
            step();
            evt = 1'b0;
        end
        rd_if.out_ready = 1'b1;
        step();
        rd_if.out_ready = 1'b0;
        evt = 1'b0;
        check("fullpop_level", 64'(level), 64'd8);
        check("fullpop_drop", 64'(drop_cnt), 64'd0);
        check("fullpop_ovf", 64'(overflow), 64'd0);
        rd_if.out_ready = 1'b1;
        for (int i = 0; i < DEPTH - 1; i++) step();
        check("fullpop_last_valid", 64'(rd_if.out_valid), 64'd1);
        check("fullpop_last_ts", rd_if.out_ts, t_new);
        step();

        // Backpressure: entries at 200 and 210, ready pattern 0,0,1,0,1
        rd_if.out_ready = 1'b0;
        rst   = 1'b1;
        count = 64'd190;
        step();
        step();
        rst = 1'b0;
        step();
        run_to(64'd200);
        evt = 1'b1;
        step();
        evt = 1'b0;
        run_to(64'd210);
        evt = 1'b1;
        step();
        evt = 1'b0;
        settle();
        check("bp_ts0", rd_if.out_ts, 64'd200);
        step();
        check("bp_ts1", rd_if.out_ts, 64'd200);
        step();
        check("bp_ts2", rd_if.out_ts, 64'd200);
        rd_if.out_ready = 1'b1;
        step();
        check("bp_ts3", rd_if.out_ts, 64'd210);
        rd_if.out_ready = 1'b0;
        step();
        check("bp_ts4", rd_if.out_ts, 64'd210);
        check("bp_valid4", 64'(rd_if.out_valid), 64'd1);
        rd_if.out_ready = 1'b1;
        step();
        check("bp_valid5", 64'(rd_if.out_valid), 64'd0);

        // clr_ovf against a simultaneous drop, then alone, then saturation
        do_reset();
        rd_if.out_ready = 1'b0;
        pulses(DEPTH + 3);
        settle();
        check("clr_pre_drop", 64'(drop_cnt), 64'd3);
        evt = 1'b1;
        for (int i = 0; i < LAT - 1; i++) begin
            step();
            evt = 1'b0;
        end
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        evt     = 1'b0;
        check("clr_drop_cnt", 64'(drop_cnt), 64'd1);
        check("clr_drop_ovf", 64'(overflow), 64'd1);
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        check("clr_alone_cnt", 64'(drop_cnt), 64'd0);
        check("clr_alone_ovf", 64'(overflow), 64'd0);
        pulses(MAXD + 2);
        settle();
        check("sat_drop", 64'(drop_cnt), 64'(MAXD));
        check("sat_level", 64'(level), 64'd8);

        // Reset mid-operation with evt held high across it
        do_reset();
        rd_if.out_ready = 1'b0;
        pulses(3);
        settle();
        check("mid_level", 64'(level), 64'd3);
        evt = 1'b1;
        step();
        rst   = 1'b1;
        count = 64'd490;
        step();
        step();
        rst = 1'b0;
        step();
        step();
        step();
        check("rr_level", 64'(level), 64'd0);
        check("rr_valid", 64'(rd_if.out_valid), 64'd0);
        evt = 1'b0;
        run_to(64'd500);
        evt = 1'b1;
        for (int i = 0; i < LAT - 1; i++) begin
            step();
            check("rr_latency", 64'(rd_if.out_valid), 64'd0);
        end
        step();
        check("rr_valid_edge", 64'(rd_if.out_valid), 64'd1);
        check("rr_ts", rd_if.out_ts, 64'd500);
        check("rr_seq", 64'(rd_if.out_seq), 64'd0);
        evt = 1'b0;

        // Random traffic across the 64-bit counter wrap
        rst   = 1'b1;
        count = 64'hFFFF_FFFF_FFFF_FFF0;
        step();
        step();
        rst = 1'b0;
        for (int i = 0; i < 800; i++) begin
            evt             = ($urandom_range(0, 2) == 0);
            rd_if.out_ready = (i < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 1);
            clr_ovf         = ($urandom_range(0, 15) == 0);
            rst             = ($urandom_range(0, 199) == 0);
            step();
        end
        rst     = 1'b0;
        clr_ovf = 1'b0;
        evt     = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
